// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Stage index constants for the classic five-stage pipe.
//   - Default stage count.
//   - Control mode enum used by the priority mux in the top.
package pipe_pkg;

  localparam int NSTAGES_DEF = 5;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // Highest priority first: a frozen pipe ignores everything else, a redirect
  // kills the load-use (it is on the wrong path), then load-use, then normal.
  typedef enum logic [1:0] {
    MODE_FREEZE   = 2'd0,
    MODE_REDIRECT = 2'd1,
    MODE_LOADUSE  = 2'd2,
    MODE_NORMAL   = 2'd3
  } ctrl_mode_e;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use detector.
// Ports:
//   i_id_valid, i_ex_valid        : ID / EX stages hold real instructions
//   i_id_rs1, i_id_rs2            : ID source registers
//   i_id_use_rs1, i_id_use_rs2    : ID instruction actually reads rs1 / rs2
//   i_ex_mem_read                 : EX instruction is a load
//   i_ex_rd                       : EX destination register
//   o_load_use                    : ID needs the value the EX load produces
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_id_valid,
  input  logic                  i_ex_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // Register 0 is hard-wired zero, so a load into it never creates a hazard.
  assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_id_valid && i_ex_valid && i_ex_mem_read &&
                      (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall / flush / valid controller for an in-order pipeline.
// Ports:
//   clk, srst          : clock, synchronous active-high reset
//   enable             : global run; low freezes the whole pipe
//   dmem_wait          : data memory not ready; freezes the whole pipe
//   id_*, ex_*         : operands for load-use detection
//   redirect           : taken branch/jump resolved in BR_STAGE
//   stage_en           : bit0 = PC enable, bit i = enable of register into stage i
//   stage_flush        : bit i = load a bubble into register feeding stage i
//   stage_valid        : stage i holds a real instruction
//   stall_cnt          : saturating count of load-use and dmem_wait stall cycles
//   flush_cnt          : saturating count of honoured redirects
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGES    = NSTAGES_DEF,
  parameter int BR_STAGE   = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic                  dmem_wait,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  redirect,
  output logic [NSTAGES-1:0]    stage_en,
  output logic [NSTAGES-1:0]    stage_flush,
  output logic [NSTAGES-1:0]    stage_valid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [NSTAGES-1:0] r_valid;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic               w_load_use;
  logic               w_redirect_ok;
  ctrl_mode_e         w_mode;
  logic [NSTAGES-1:0] w_en;
  logic [NSTAGES-1:0] w_flush;
  logic [NSTAGES-1:0] w_valid_nxt;
  logic               w_stall_inc;
  logic               w_flush_inc;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .i_id_valid   (r_valid[ST_ID]),
    .i_ex_valid   (r_valid[ST_EX]),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .i_ex_mem_read(ex_mem_read),
    .i_ex_rd      (ex_rd),
    .o_load_use   (w_load_use)
  );

  // A redirect from a bubble in the resolve stage is stale and must be ignored.
  assign w_redirect_ok = redirect && r_valid[BR_STAGE];

  always_comb begin
    if (!enable || dmem_wait)  w_mode = MODE_FREEZE;
    else if (w_redirect_ok)    w_mode = MODE_REDIRECT;
    else if (w_load_use)       w_mode = MODE_LOADUSE;
    else                       w_mode = MODE_NORMAL;
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_en    = '1;
    w_flush = '0;
    unique case (w_mode)
      MODE_FREEZE: w_en = '0;
      MODE_REDIRECT: begin
        // Kill every younger instruction fetched down the wrong path.
        for (int i = 1; i < NSTAGES; i++) begin
          if (i <= BR_STAGE) w_flush[i] = 1'b1;
        end
      end
      MODE_LOADUSE: begin
        // Hold PC and the ID register, inject one bubble into EX.
        w_en[ST_IF]    = 1'b0;
        w_en[ST_ID]    = 1'b0;
        w_flush[ST_EX] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_en[0]) w_valid_nxt[0] = 1'b1;
    for (int i = 1; i < NSTAGES; i++) begin
      if (w_en[i]) w_valid_nxt[i] = r_valid[i-1] && !w_flush[i];
    end
  end

  assign w_stall_inc = (enable && dmem_wait) || (w_mode == MODE_LOADUSE);
  assign w_flush_inc = (w_mode == MODE_REDIRECT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_valid     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stage_en    = w_en;
  assign stage_flush = w_flush;
  assign stage_valid = r_valid;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. The driver applies one vector per
// cycle on the falling edge and queues the hand-computed expected outputs for
// that cycle; the monitor samples the DUT late in the low phase and compares.
// A second instance with CNT_W=4 shares all inputs to exercise saturation.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int AW = 5;

  typedef struct {
    string        name;
    logic [NS-1:0] en;
    logic [NS-1:0] fl;
    logic [NS-1:0] v;
    int           st;
    int           fc;
    int           st_small;
  } exp_t;

  logic          clk = 1'b0;
  logic          srst;
  logic          enable;
  logic          dmem_wait;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, redirect;

  logic [NS-1:0] stage_en, stage_flush, stage_valid;
  logic [31:0]   stall_cnt, flush_cnt;
  logic [NS-1:0] s_en, s_flush, s_valid;
  logic [3:0]    s_stall_cnt, s_flush_cnt;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGES(NS), .BR_STAGE(3), .REG_ADDR_W(AW), .CNT_W(32)) u_dut (
    .clk(clk), .srst(srst), .enable(enable), .dmem_wait(dmem_wait),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .redirect(redirect),
    .stage_en(stage_en), .stage_flush(stage_flush), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.NSTAGES(NS), .BR_STAGE(3), .REG_ADDR_W(AW), .CNT_W(4)) u_dut_small (
    .clk(clk), .srst(srst), .enable(enable), .dmem_wait(dmem_wait),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .redirect(redirect),
    .stage_en(s_en), .stage_flush(s_flush), .stage_valid(s_valid),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one sample per cycle, late in the low phase, away from posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".stage_en"},    32'(stage_en),    32'(e.en));
        check({e.name, ".stage_flush"}, 32'(stage_flush), 32'(e.fl));
        check({e.name, ".stage_valid"}, 32'(stage_valid), 32'(e.v));
        check({e.name, ".stall_cnt"},   stall_cnt,        32'(e.st));
        check({e.name, ".flush_cnt"},   flush_cnt,        32'(e.fc));
        check({e.name, ".small_stall"}, 32'(s_stall_cnt), 32'(e.st_small));
      end
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic en_i, input logic dw,
                     input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                     input logic u2, input logic mr, input logic [AW-1:0] rd, input logic rdr,
                     input logic [NS-1:0] e_en, input logic [NS-1:0] e_fl,
                     input logic [NS-1:0] e_v, input int e_st, input int e_fc);
    exp_t e;
    @(negedge clk);
    srst = rst; enable = en_i; dmem_wait = dw;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; redirect = rdr;
    e.name = nm; e.en = e_en; e.fl = e_fl; e.v = e_v; e.st = e_st; e.fc = e_fc;
    e.st_small = (e_st > 15) ? 15 : e_st;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [NS-1:0] e_v, input int e_st, input int e_fc);
    cyc(nm, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, e_v, e_st, e_fc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    srst = 1; enable = 0; dmem_wait = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_rd = 0; redirect = 0;
    repeat (2) @(posedge clk);

    // Reset state, then valid fill with no hazards.
    cyc("reset", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b00000, 0, 0);
    idle("fill0", 5'b00000, 0, 0);
    idle("fill1", 5'b00001, 0, 0);
    idle("fill2", 5'b00011, 0, 0);
    idle("fill3", 5'b00111, 0, 0);
    idle("fill4", 5'b01111, 0, 0);
    idle("fill5", 5'b11111, 0, 0);

    // Load-use on rs1.
    cyc("lu_rs1", 0, 1, 0, 5, 1, 0, 0, 1, 5, 0, 5'b11100, 5'b00100, 5'b11111, 0, 0);
    idle("lu_rs1_after", 5'b11011, 1, 0);
    // Load into x0 and unused operand: no stall.
    cyc("nolu_rd0", 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 5'b11111, 5'b00000, 5'b10111, 1, 0);
    cyc("nolu_use0", 0, 1, 0, 5, 0, 5, 0, 1, 5, 0, 5'b11111, 5'b00000, 5'b01111, 1, 0);
    // Load-use on rs2.
    cyc("lu_rs2", 0, 1, 0, 0, 1, 7, 1, 1, 7, 0, 5'b11100, 5'b00100, 5'b11111, 1, 0);
    idle("lu_rs2_a1", 5'b11011, 2, 0);
    idle("lu_rs2_a2", 5'b10111, 2, 0);
    idle("lu_rs2_a3", 5'b01111, 2, 0);

    // Honoured redirect, then a redirect from a bubble in BR_STAGE.
    cyc("redir", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 5'b01110, 5'b11111, 2, 0);
    idle("redir_after", 5'b10001, 2, 1);
    cyc("redir_novalid", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 5'b00000, 5'b00011, 2, 1);
    idle("refill_a", 5'b00111, 2, 1);
    idle("refill_b", 5'b01111, 2, 1);

    // Redirect wins over a simultaneous load-use.
    cyc("redir_lu", 0, 1, 0, 5, 1, 0, 0, 1, 5, 1, 5'b11111, 5'b01110, 5'b11111, 2, 1);
    idle("redir_lu_a1", 5'b10001, 2, 2);
    idle("redir_lu_a2", 5'b00011, 2, 2);
    idle("redir_lu_a3", 5'b00111, 2, 2);
    idle("redir_lu_a4", 5'b01111, 2, 2);

    // dmem_wait freeze for three cycles.
    cyc("dmw1", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b11111, 2, 2);
    cyc("dmw2", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b11111, 3, 2);
    cyc("dmw3", 0, 1, 1, 5, 1, 0, 0, 1, 5, 1, 5'b00000, 5'b00000, 5'b11111, 4, 2);
    // Global disable: frozen, counters unchanged even with dmem_wait.
    cyc("dis1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b11111, 5, 2);
    cyc("dis2", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b11111, 5, 2);
    cyc("dis3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b11111, 5, 2);
    // Reset mid-freeze.
    cyc("rst_frz", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b11111, 5, 2);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0);

    // Long dmem_wait: the 4-bit instance saturates at 15.
    for (int k = 0; k < 20; k++) begin
      cyc($sformatf("sat%0d", k), 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,
          5'b00000, 5'b00000, 5'b00000, k, 0);
    end
    idle("sat_end", 5'b00000, 20, 0);

    // Drain the scoreboard with a bounded wait.
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    #4;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
